laplacian_capture: RTL and testbench
====================================

LAPLACIAN_CAPTURE -- requirements
Module: laplacian_capture

Interface
REQ-001 The module SHALL have parameter IMG_W, default 16: pixels per line of the captured frame.
REQ-002 The module SHALL have parameter IMG_H, default 16: lines per captured frame.
REQ-003 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle pulse that arms a new frame capture.
REQ-006 The module SHALL have port valid_in, input, 1 bit: input pixel qualifier, driven by the filter's valid_out.
REQ-007 The module SHALL have port pixel_in, input, 8 bits: input pixel, driven by the filter's pixel_out.
REQ-008 The module SHALL have port rd_req, input, 1 bit: request for the next stored pixel in raster order.
REQ-009 The module SHALL have port rd_valid, output, 1 bit: rd_pixel holds valid data this cycle.
REQ-010 The module SHALL have port rd_pixel, output, 8 bits: read-back pixel.
REQ-011 The module SHALL have port rd_last, output, 1 bit: asserted together with rd_valid on the final pixel of the frame.
REQ-012 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse when the frame is fully captured.
REQ-013 The module SHALL have port overrun, output, 1 bit: sticky flag indicating an input pixel was dropped.
REQ-014 The module SHALL have port busy, output, 1 bit: high in the CAPTURE or READOUT state.

Function
REQ-015 The module SHALL implement the states IDLE, CAPTURE, DONE and READOUT, with storage of IMG_W*IMG_H 8-bit pixels.
REQ-016 In every state, start SHALL clear the write and read addresses and overrun, and move to CAPTURE; valid_in in the start cycle is discarded and does not set overrun.
REQ-017 In CAPTURE, each valid_in cycle SHALL store pixel_in at the write address and increment the write address; there is no backpressure, so every valid pixel is accepted.
REQ-018 When the pixel at address IMG_W*IMG_H-1 is stored, the state SHALL become DONE and frame_done SHALL pulse high for exactly one cycle on the next cycle.
REQ-019 In IDLE, DONE or READOUT, valid_in SHALL be dropped, SHALL set overrun, and SHALL NOT modify storage.
REQ-020 In DONE or READOUT, rd_req SHALL return the pixel at the read address one cycle later on rd_pixel with rd_valid=1, and SHALL increment the read address.
REQ-021 The first rd_req in DONE SHALL move the state to READOUT.
REQ-022 On the read of address IMG_W*IMG_H-1, rd_last SHALL assert with rd_valid, and the state SHALL become IDLE in the cycle in which that data is presented.
REQ-023 Back-to-back rd_req SHALL yield one pixel per cycle; a gap in rd_req SHALL produce a gap in rd_valid.
REQ-024 rd_req in IDLE or CAPTURE SHALL be ignored: rd_valid stays 0 and the read address is unchanged.
REQ-025 rd_pixel SHALL hold its last value when rd_valid=0; rd_valid and rd_last are single-cycle per request.
REQ-026 Both address counters SHALL be wide enough for IMG_W*IMG_H-1 and SHALL never wrap within a frame.

Reset
REQ-027 While rst=1, the state SHALL be IDLE and rd_valid, rd_pixel, rd_last, frame_done, overrun, busy and both addresses SHALL be 0.
REQ-028 rst SHALL have priority over start, valid_in and rd_req; storage contents need not be cleared.
REQ-029 rst asserted mid-CAPTURE or mid-READOUT SHALL abandon the frame; no frame_done or rd_last is emitted for it.

Configuration
REQ-030 When macro CAPTURE_CHECKSUM_EN is defined, the module SHALL add output checksum (16 bits): the modulo-2^16 sum of all pixels stored in the current frame, cleared by rst and start, and stable from frame_done until the next start.
REQ-031 When CAPTURE_CHECKSUM_EN is undefined, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Verification (IMG_W=4, IMG_H=4)
REQ-032 The bench SHALL cover: start, then 16 valid pixels 0..15 -> frame_done exactly one cycle after pixel 15; 16 back-to-back rd_req -> rd_pixel 0..15 one cycle after each request, rd_last with 15, state returns to IDLE.
REQ-033 The bench SHALL cover: valid_in with pixel 0xAA while IDLE -> overrun=1 and storage unchanged; the next start clears overrun to 0.
REQ-034 The bench SHALL cover: start, 8 pixels, start again, 16 pixels 0x80..0x8F -> a single frame_done; readback gives 0x80..0x8F.
REQ-035 The bench SHALL cover: rst asserted after 5 captured pixels -> all outputs 0 next cycle, no frame_done, and rd_req then produces no rd_valid.
REQ-036 The bench SHALL cover: valid_in gapped every other cycle -> the frame completes after 16 valid pixels; readback alternating rd_req -> rd_valid alternates.
REQ-037 The bench SHALL cover, with CAPTURE_CHECKSUM_EN defined: 16 pixels of 0xFF -> checksum=0x0FF0 at frame_done.

Source files
------------

// File: rtl/laplacian_capture_if.sv
// Bus between the Laplacian filter side and the frame-capture buffer.
// With CAPTURE_CHECKSUM_EN defined, the bus also carries the running frame checksum.
interface laplacian_capture_if;
    logic       start;
    logic       valid_in;
    logic [7:0] pixel_in;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_pixel;
    logic       rd_last;
    logic       frame_done;
    logic       overrun;
    logic       busy;
`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] checksum;

    modport master (
        output start, valid_in, pixel_in, rd_req,
        input  rd_valid, rd_pixel, rd_last, frame_done, overrun, busy, checksum
    );
    modport slave (
        input  start, valid_in, pixel_in, rd_req,
        output rd_valid, rd_pixel, rd_last, frame_done, overrun, busy, checksum
    );
`else
    modport master (
        output start, valid_in, pixel_in, rd_req,
        input  rd_valid, rd_pixel, rd_last, frame_done, overrun, busy
    );
    modport slave (
        input  start, valid_in, pixel_in, rd_req,
        output rd_valid, rd_pixel, rd_last, frame_done, overrun, busy
    );
`endif
endinterface

// File: rtl/laplacian_capture.sv
// Captures one IMG_W x IMG_H frame of filtered pixels and reads it back in raster order.
// Optional feature macro: CAPTURE_CHECKSUM_EN adds a modulo-2^16 checksum of the captured frame.
module laplacian_capture #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic              CLK,
    input  logic              rst,
    laplacian_capture_if.slave bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE, READOUT} state_t;

    state_t        state_q;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]    mem_q [NPIX];
    logic          rd_valid_q;
    logic [7:0]    rd_pixel_q;
    logic          rd_last_q;
    logic          frame_done_q;
    logic          overrun_q;
    logic          wr_en;
    logic          rd_en;

    // start and rst both pre-empt any store or read in the same cycle
    assign wr_en = !rst && !bus.start && (state_q == CAPTURE) && bus.valid_in;
    assign rd_en = !rst && !bus.start && ((state_q == DONE) || (state_q == READOUT)) && bus.rd_req;

    // Addresses saturate at the last pixel so they can never wrap inside a frame
    assign wr_addr_d = (wr_addr_q == LAST_ADDR) ? wr_addr_q : wr_addr_q + AW'(1);
    assign rd_addr_d = (rd_addr_q == LAST_ADDR) ? rd_addr_q : rd_addr_q + AW'(1);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr_q] <= bus.pixel_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_pixel_q   <= '0;
            rd_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.start) begin
                state_q   <= CAPTURE;
                wr_addr_q <= '0;
                rd_addr_q <= '0;
                overrun_q <= 1'b0;
            end else begin
                if (bus.valid_in && (state_q != CAPTURE)) begin
                    overrun_q <= 1'b1;
                end
                case (state_q)
                    CAPTURE: begin
                        if (wr_en) begin
                            wr_addr_q <= wr_addr_d;
                            if (wr_addr_q == LAST_ADDR) begin
                                state_q      <= DONE;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                    DONE, READOUT: begin
                        if (rd_en) begin
                            rd_valid_q <= 1'b1;
                            rd_pixel_q <= mem_q[rd_addr_q];
                            rd_last_q  <= (rd_addr_q == LAST_ADDR);
                            rd_addr_q  <= rd_addr_d;
                            state_q    <= (rd_addr_q == LAST_ADDR) ? IDLE : READOUT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge CLK) begin
        if (rst || bus.start) begin
            checksum_q <= '0;
        end else if (wr_en) begin
            checksum_q <= checksum_q + 16'(bus.pixel_in);
        end
    end

    assign bus.checksum = checksum_q;
`endif

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_pixel   = rd_pixel_q;
    assign bus.rd_last    = rd_last_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q == CAPTURE) || (state_q == READOUT);
endmodule

// File: tb/tb_laplacian_capture.sv
// Directed bench for laplacian_capture (4x4 frame) with a readback scoreboard queue.
module tb_laplacian_capture;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] px;
        logic       last;
    } rd_exp_t;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    laplacian_capture_if bus();

    laplacian_capture #(.IMG_W(W), .IMG_H(H)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    rd_exp_t     q[$];
    logic [7:0]  tb_mem [N];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    bit          cap    = 0;
    bit          rd_ok  = 0;
    bit          ovr    = 0;
    logic [15:0] csum   = '0;
    logic [7:0]  last_px = '0;
    bit          pend_v  = 0;
    bit          pend_fd = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit      exp_v;
        bit      exp_fd;
        rd_exp_t e;
        exp_v   = pend_v;
        exp_fd  = pend_fd;
        pend_v  = 0;
        pend_fd = 0;
        @(posedge CLK);
        #1;
        chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, exp_v});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, exp_fd});
        chk("overrun", {31'd0, bus.overrun}, {31'd0, ovr});
        chk("busy", {31'd0, bus.busy}, {31'd0, (cap || (rd_ok && rd_ptr > 0))});
`ifdef CAPTURE_CHECKSUM_EN
        chk("checksum", {16'd0, bus.checksum}, {16'd0, csum});
`endif
        if (bus.rd_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("rd_pixel", {24'd0, bus.rd_pixel}, {24'd0, e.px});
            chk("rd_last", {31'd0, bus.rd_last}, {31'd0, e.last});
            last_px = e.px;
        end else begin
            chk("rd_pixel_hold", {24'd0, bus.rd_pixel}, {24'd0, last_px});
            chk("rd_last_idle", {31'd0, bus.rd_last}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cap = 0; rd_ok = 0; ovr = 0; csum = '0;
        wr_ptr = 0; rd_ptr = 0; last_px = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input bit with_valid);
        bus.start    = 1'b1;
        bus.valid_in = with_valid;
        bus.pixel_in = 8'h55;
        cap = 1; rd_ok = 0; ovr = 0; csum = '0;
        wr_ptr = 0; rd_ptr = 0;
        tick();
        bus.start    = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    task automatic wr(input logic [7:0] px);
        bus.valid_in = 1'b1;
        bus.pixel_in = px;
        if (cap) begin
            tb_mem[wr_ptr] = px;
            csum = csum + 16'(px);
            wr_ptr = wr_ptr + 1;
            if (wr_ptr == N) begin
                pend_fd = 1;
                cap     = 0;
                rd_ok   = 1;
            end
        end else begin
            ovr = 1;
        end
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic rd();
        bus.rd_req = 1'b1;
        if (rd_ok) begin
            q.push_back('{px: tb_mem[rd_ptr], last: (rd_ptr == N - 1)});
            pend_v = 1;
            if (rd_ptr == N - 1) rd_ok = 0;
            rd_ptr = rd_ptr + 1;
        end
        tick();
        bus.rd_req = 1'b0;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.valid_in = 1'b0;
        bus.pixel_in = 8'h00;
        bus.rd_req   = 1'b0;

        // Reset state
        do_reset();
        do_reset();

        // Full frame 0..15, back-to-back readback, return to IDLE
        do_start(1'b0);
        for (int i = 0; i < N; i++) wr(8'(i));
        tick();
        for (int i = 0; i < N; i++) rd();
        tick();
        rd();

        // Drop in IDLE sets overrun; next start (with a discarded valid) clears it
        wr(8'hAA);
        do_start(1'b1);

        // Restarted capture: 8 pixels, start again, 16 pixels 0x80..0x8F
        for (int i = 0; i < 8; i++) wr(8'(8'h20 + i));
        rd();
        do_start(1'b1);
        for (int i = 0; i < N; i++) begin
            wr(8'(8'h80 + i));
            if (i == 5) rd();
        end
        wr(8'hAA);
        for (int i = 0; i < N; i++) rd();

        // Reset mid-capture abandons the frame
        do_start(1'b0);
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
        do_reset();
        chk("rst_rd_pixel", {24'd0, bus.rd_pixel}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rd();
        rd();

        // Gapped capture and alternating readback, then reset mid-readout
        do_start(1'b0);
        for (int i = 0; i < N; i++) begin
            wr(8'($urandom_range(0, 255)));
            tick();
        end
        for (int i = 0; i < N; i++) begin
            rd();
            tick();
        end
        do_start(1'b0);
        for (int i = 0; i < N; i++) wr(8'(8'hC0 + i));
        for (int i = 0; i < 5; i++) rd();
        do_reset();
        rd();
        rd();

`ifdef CAPTURE_CHECKSUM_EN
        // Checksum of a frame of 0xFF pixels
        do_start(1'b0);
        for (int i = 0; i < N; i++) wr(8'hFF);
        chk("checksum_0FF0", {16'd0, bus.checksum}, 32'h0FF0);
        tick();
        tick();
        chk("checksum_hold", {16'd0, bus.checksum}, 32'h0FF0);
`endif

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
